// File: rtl/scalar_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scalar_mult_pkg
// Description : Shared ECC definitions for the point-level blocks. It holds
//               the scalar-multiplier state encoding, the projective point
//               type, the group identity (0,1,1) and the field modulus
//               p = 2^255 - 19.
// Revision    : 1.0 - initial release
// ============================================================================
package scalar_mult_pkg;

    localparam int unsigned c_COORD_W = 255;

    // Field modulus. Written as (2^255 - 1) - 18 so no hex digit can be mistyped.
    localparam logic [c_COORD_W-1:0] c_P_MOD = {c_COORD_W{1'b1}} - 255'd18;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DBL_REQ  = 3'd1,
        S_DBL_WAIT = 3'd2,
        S_ADD_REQ  = 3'd3,
        S_ADD_WAIT = 3'd4,
        S_DONE     = 3'd5
    } sm_state_t;

    typedef struct packed {
        logic [c_COORD_W-1:0] x;
        logic [c_COORD_W-1:0] y;
        logic [c_COORD_W-1:0] z;
    } point_t;

    // Neutral element of the twisted Edwards group in projective form.
    localparam point_t c_IDENTITY = '{x: '0, y: 255'd1, z: 255'd1};

    localparam point_t c_POINT_ZERO = '{x: '0, y: '0, z: '0};

endpackage : scalar_mult_pkg
`default_nettype wire

// File: rtl/scalar_mult.sv
`default_nettype none
// ============================================================================
// Module      : scalar_mult
// Description : Constant-time left-to-right double-and-always-add scalar
//               multiplier sequencer. It performs no field arithmetic; it
//               steers operands to an external point add/double unit and
//               selects which results are kept.
//
// Ports
//   i_clk, i_rst           : clock, synchronous active-high reset
//   i_start                : request, accepted only when idle
//   i_k, i_px, i_py        : scalar and affine base point, latched on start
//   o_x, o_y, o_z          : projective result k*P, held until next start
//   o_busy                 : high whenever a run is in progress
//   o_finished             : one-cycle completion pulse
//   o_pa_start             : one-cycle request to the point unit
//   o_pa_doubling          : 1 = doubling, 0 = addition
//   o_pa_{x,y,z}{1,2}      : operands to the point unit, held while waiting
//   i_pa_{x,y,z}3          : result from the point unit
//   i_pa_finished          : one-cycle result-valid pulse from the point unit
//
// Revision    : 1.0 - initial release
// ============================================================================
module scalar_mult
    import scalar_mult_pkg::*;
(
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_start,
    input  logic [254:0]   i_k,
    input  logic [254:0]   i_px,
    input  logic [254:0]   i_py,
    output logic [254:0]   o_x,
    output logic [254:0]   o_y,
    output logic [254:0]   o_z,
    output logic           o_busy,
    output logic           o_finished,
    output logic           o_pa_start,
    output logic           o_pa_doubling,
    output logic [254:0]   o_pa_x1,
    output logic [254:0]   o_pa_y1,
    output logic [254:0]   o_pa_z1,
    output logic [254:0]   o_pa_x2,
    output logic [254:0]   o_pa_y2,
    output logic [254:0]   o_pa_z2,
    input  logic [254:0]   i_pa_x3,
    input  logic [254:0]   i_pa_y3,
    input  logic [254:0]   i_pa_z3,
    input  logic           i_pa_finished
);

    localparam logic [7:0] c_TOP_BIT = 8'd254;

    sm_state_t      state_q,    state_d;
    logic [254:0]   k_q,        k_d;
    logic [7:0]     idx_q,      idx_d;
    point_t         p_q,        p_d;
    point_t         r_q,        r_d;
    point_t         res_q,      res_d;
    logic           busy_q,     busy_d;
    logic           fin_q,      fin_d;
    logic           pa_start_q, pa_start_d;
    logic           pa_dbl_q,   pa_dbl_d;
    point_t         op1_q,      op1_d;
    point_t         op2_q,      op2_d;

    point_t         pa_result;

    assign pa_result = '{x: i_pa_x3, y: i_pa_y3, z: i_pa_z3};

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        idx_d      = idx_q;
        p_d        = p_q;
        r_d        = r_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    k_d     = i_k;
                    p_d     = '{x: i_px, y: i_py, z: 255'd1};
                    r_d     = c_IDENTITY;
                    idx_d   = c_TOP_BIT;
                    state_d = S_DBL_REQ;
                end
            end
            S_DBL_REQ: state_d = S_DBL_WAIT;
            S_DBL_WAIT: begin
                if (i_pa_finished) begin
                    r_d     = pa_result;
                    state_d = S_ADD_REQ;
                end
            end
            S_ADD_REQ: state_d = S_ADD_WAIT;
            S_ADD_WAIT: begin
                if (i_pa_finished) begin
                    // The addition always runs; keeping its result only for
                    // set bits makes the schedule independent of k.
                    if (k_q[idx_q]) begin
                        r_d = pa_result;
                    end
                    if (idx_q == 8'd0) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q - 8'd1;
                        state_d = S_DBL_REQ;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Every output is a register loaded from the next-state decode, so
        // each output reflects the state it belongs to in the same cycle.
        busy_d     = (state_d != S_IDLE);
        fin_d      = (state_d == S_DONE);
        res_d      = (state_d == S_DONE) ? r_d : res_q;
        pa_start_d = (state_d == S_DBL_REQ) || (state_d == S_ADD_REQ);

        case (state_d)
            S_DBL_REQ, S_DBL_WAIT: begin
                pa_dbl_d = 1'b1;
                op1_d    = r_d;
                op2_d    = r_d;
            end
            S_ADD_REQ, S_ADD_WAIT: begin
                pa_dbl_d = 1'b0;
                op1_d    = r_d;
                op2_d    = p_d;
            end
            default: begin
                pa_dbl_d = 1'b0;
                op1_d    = c_POINT_ZERO;
                op2_d    = c_POINT_ZERO;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            idx_q      <= '0;
            p_q        <= c_POINT_ZERO;
            r_q        <= c_IDENTITY;
            res_q      <= c_POINT_ZERO;
            busy_q     <= 1'b0;
            fin_q      <= 1'b0;
            pa_start_q <= 1'b0;
            pa_dbl_q   <= 1'b0;
            op1_q      <= c_POINT_ZERO;
            op2_q      <= c_POINT_ZERO;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            idx_q      <= idx_d;
            p_q        <= p_d;
            r_q        <= r_d;
            res_q      <= res_d;
            busy_q     <= busy_d;
            fin_q      <= fin_d;
            pa_start_q <= pa_start_d;
            pa_dbl_q   <= pa_dbl_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
        end
    end

    assign o_x           = res_q.x;
    assign o_y           = res_q.y;
    assign o_z           = res_q.z;
    assign o_busy        = busy_q;
    assign o_finished    = fin_q;
    assign o_pa_start    = pa_start_q;
    assign o_pa_doubling = pa_dbl_q;
    assign o_pa_x1       = op1_q.x;
    assign o_pa_y1       = op1_q.y;
    assign o_pa_z1       = op1_q.z;
    assign o_pa_x2       = op2_q.x;
    assign o_pa_y2       = op2_q.y;
    assign o_pa_z2       = op2_q.z;

endmodule : scalar_mult
`default_nettype wire

// File: tb/tb_scalar_mult.sv
`default_nettype none
// ============================================================================
// Module      : tb_scalar_mult
// Description : Self-checking bench for scalar_mult. A behavioural Ed25519
//               point unit (unified twisted Edwards addition, 20-cycle
//               latency) answers the requests; results are compared against
//               reference multiples of the base point built from the same
//               group law.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scalar_mult;
    import scalar_mult_pkg::*;

    localparam logic [254:0] c_BX  = 255'h216936d3cd6e53fec0a4e231fdd6dc5c692cc7609525a7b2c9562d608f25d51a;
    localparam logic [254:0] c_BY  = 255'h6666666666666666666666666666666666666666666666666666666666666658;
    localparam logic [254:0] c_D   = 255'h52036cee2b6ffe738cc740797779e89800700a4d4141d8ab75eb4dca135978a3;
    localparam int           c_LAT = 20;
    localparam int           c_RUN_CYCLES = 1 + 510 * (c_LAT + 1);

    logic         clk = 1'b0;
    logic         i_rst, i_start, i_pa_finished;
    logic [254:0] i_k, i_px, i_py, i_pa_x3, i_pa_y3, i_pa_z3;
    logic [254:0] o_x, o_y, o_z;
    logic [254:0] o_pa_x1, o_pa_y1, o_pa_z1, o_pa_x2, o_pa_y2, o_pa_z2;
    logic         o_busy, o_finished, o_pa_start, o_pa_doubling;

    scalar_mult u_dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_k          (i_k),
        .i_px         (i_px),
        .i_py         (i_py),
        .o_x          (o_x),
        .o_y          (o_y),
        .o_z          (o_z),
        .o_busy       (o_busy),
        .o_finished   (o_finished),
        .o_pa_start   (o_pa_start),
        .o_pa_doubling(o_pa_doubling),
        .o_pa_x1      (o_pa_x1),
        .o_pa_y1      (o_pa_y1),
        .o_pa_z1      (o_pa_z1),
        .o_pa_x2      (o_pa_x2),
        .o_pa_y2      (o_pa_y2),
        .o_pa_z2      (o_pa_z2),
        .i_pa_x3      (i_pa_x3),
        .i_pa_y3      (i_pa_y3),
        .i_pa_z3      (i_pa_z3),
        .i_pa_finished(i_pa_finished)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- field and group reference ----------------
    function automatic logic [254:0] fadd(input logic [254:0] a, input logic [254:0] b);
        logic [255:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, c_P_MOD}) s = s - {1'b0, c_P_MOD};
        return s[254:0];
    endfunction

    function automatic logic [254:0] fsub(input logic [254:0] a, input logic [254:0] b);
        return fadd(a, c_P_MOD - b);
    endfunction

    function automatic logic [254:0] fmul(input logic [254:0] a, input logic [254:0] b);
        logic [509:0] t;
        t = {255'd0, a} * {255'd0, b};
        t = t % {255'd0, c_P_MOD};
        return t[254:0];
    endfunction

    // Unified projective addition on -x^2 + y^2 = 1 + d x^2 y^2.
    function automatic point_t padd(input point_t p1, input point_t p2);
        logic [254:0] a, b, c, d, e, f, g;
        point_t r;
        a = fmul(p1.z, p2.z);
        b = fmul(a, a);
        c = fmul(p1.x, p2.x);
        d = fmul(p1.y, p2.y);
        e = fmul(fmul(c_D, c), d);
        f = fsub(b, e);
        g = fadd(b, e);
        r.x = fmul(fmul(a, f), fsub(fsub(fmul(fadd(p1.x, p1.y), fadd(p2.x, p2.y)), c), d));
        r.y = fmul(fmul(a, g), fadd(d, c));
        r.z = fmul(f, g);
        return r;
    endfunction

    // ---------------- point unit model + protocol monitor ----------------
    logic [254:0] cur_px = '0, cur_py = '0;
    bit           spur_en = 1'b0;
    bit           pend = 1'b0, waiting = 1'b0, prev_start = 1'b0, exp_dbl = 1'b1;
    int           cnt = 0, last_fin = 0, fin_gap = 0;
    int           n_req = 0, n_dbl = 0, n_spur = 0, fin_cnt = 0;
    int           alt_err = 0, stab_err = 0, op_err = 0, width_err = 0, idle_err = 0;
    point_t       resp, snap1, snap2;
    logic         snap_dbl;

    initial begin
        i_pa_finished = 1'b0;
        i_pa_x3 = '0; i_pa_y3 = '0; i_pa_z3 = '0;
    end

    always @(negedge clk) begin
        if (i_rst) begin
            pend = 1'b0; cnt = 0; waiting = 1'b0; prev_start = 1'b0; exp_dbl = 1'b1;
            i_pa_finished = 1'b0;
        end else begin
            if (o_finished) begin
                fin_cnt++;
                fin_gap = cyc - last_fin;
            end
            if (!o_busy && ((o_pa_x1 | o_pa_y1 | o_pa_z1 | o_pa_x2 | o_pa_y2 | o_pa_z2) != '0))
                idle_err++;
            if (waiting && !o_pa_start) begin
                if (o_pa_doubling != snap_dbl
                    || {o_pa_x1, o_pa_y1, o_pa_z1} != snap1
                    || {o_pa_x2, o_pa_y2, o_pa_z2} != snap2)
                    stab_err++;
            end
            i_pa_finished = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    {i_pa_x3, i_pa_y3, i_pa_z3} = resp;
                    i_pa_finished = 1'b1;
                    pend = 1'b0;
                    waiting = 1'b0;
                    last_fin = cyc;
                end
            end
            if (o_pa_start) begin
                if (prev_start) width_err++;
                n_req++;
                if (o_pa_doubling) n_dbl++;
                if (o_pa_doubling != exp_dbl) alt_err++;
                exp_dbl = ~exp_dbl;
                snap_dbl = o_pa_doubling;
                snap1 = '{x: o_pa_x1, y: o_pa_y1, z: o_pa_z1};
                snap2 = '{x: o_pa_x2, y: o_pa_y2, z: o_pa_z2};
                if (o_pa_doubling ? (snap1 != snap2)
                                  : (snap2 != '{x: cur_px, y: cur_py, z: 255'd1}))
                    op_err++;
                waiting = 1'b1;
                resp = padd(snap1, snap2);
                pend = 1'b1;
                cnt = c_LAT;
                // Garbage result pulsed while the DUT sits in S_DBL_REQ.
                if (spur_en && o_pa_doubling) begin
                    i_pa_x3 = 255'h1111; i_pa_y3 = 255'h2222; i_pa_z3 = 255'h3333;
                    i_pa_finished = 1'b1;
                    n_spur++;
                end
            end
            prev_start = o_pa_start;
        end
    end

    // ---------------- checking ----------------
    int n_cmp = 0, n_bad = 0;

    task automatic check_eq(input string tag, input logic [254:0] obs, input logic [254:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Projective results are compared by cross-multiplication against a reference.
    task automatic check_point(input string tag, input point_t got, input point_t ref_pt);
        check_eq({tag, "_x"}, fmul(got.x, ref_pt.z), fmul(ref_pt.x, got.z));
        check_eq({tag, "_y"}, fmul(got.y, ref_pt.z), fmul(ref_pt.y, got.z));
        check_eq({tag, "_znz"}, 255'(got.z == '0), 255'd0);
    endtask

    task automatic do_run(input string tag, input logic [254:0] k, input bit disturb,
                          output int cycles, output point_t res);
        int b_req, b_dbl, b_alt, b_stab, b_op, b_wid, b_idle, b_fin, b_spur, t0;
        bit got;
        b_req = n_req; b_dbl = n_dbl; b_alt = alt_err; b_stab = stab_err; b_op = op_err;
        b_wid = width_err; b_idle = idle_err; b_fin = fin_cnt; b_spur = n_spur;
        cur_px = c_BX; cur_py = c_BY;
        spur_en = disturb;
        @(negedge clk);
        i_start = 1'b1; i_k = k; i_px = c_BX; i_py = c_BY;
        t0 = cyc;
        @(negedge clk);
        // Scramble the inputs: the DUT must work from its latched copies.
        i_start = 1'b0; i_k = ~k; i_px = '0; i_py = '0;
        got = 1'b0;
        for (int n = 0; n < 12000 && !got; n++) begin
            if (o_finished) begin
                got = 1'b1;
            end else begin
                if (disturb && n == 300) begin
                    i_start = 1'b1; i_k = '1; i_px = 255'h5; i_py = 255'h7;
                end else begin
                    i_start = 1'b0;
                end
                @(negedge clk);
            end
        end
        check_eq({tag, "_done"}, 255'(got), 255'd1);
        cycles = cyc - t0;
        res = '{x: o_x, y: o_y, z: o_z};
        spur_en = 1'b0;
        repeat (2) @(negedge clk);
        check_eq({tag, "_nreq"},  255'(n_req - b_req), 255'd510);
        check_eq({tag, "_ndbl"},  255'(n_dbl - b_dbl), 255'd255);
        check_eq({tag, "_alt"},   255'(alt_err - b_alt), 255'd0);
        check_eq({tag, "_stab"},  255'(stab_err - b_stab), 255'd0);
        check_eq({tag, "_oper"},  255'(op_err - b_op), 255'd0);
        check_eq({tag, "_width"}, 255'(width_err - b_wid), 255'd0);
        check_eq({tag, "_idle"},  255'(idle_err - b_idle), 255'd0);
        check_eq({tag, "_nfin"},  255'(fin_cnt - b_fin), 255'd1);
        check_eq({tag, "_gap"},   255'(fin_gap), 255'd1);
        check_eq({tag, "_cyc"},   255'(cycles), 255'(c_RUN_CYCLES));
        if (disturb) check_eq({tag, "_spur"}, 255'(n_spur - b_spur), 255'd255);
        check_eq({tag, "_held"}, o_x, res.x);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        point_t base, ref2, refbig, res, res2;
        int     cyc2, cycb, cyc_tmp, reqs, b_fin;
        bit     hit;

        base = '{x: c_BX, y: c_BY, z: 255'd1};
        i_rst = 1'b1; i_start = 1'b0; i_k = '0; i_px = '0; i_py = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_x",    o_x, '0);
        check_eq("rst_y",    o_y, '0);
        check_eq("rst_z",    o_z, '0);
        check_eq("rst_ctl",  255'({o_busy, o_finished, o_pa_start, o_pa_doubling}), 255'd0);
        check_eq("rst_ops",  o_pa_x1 | o_pa_y1 | o_pa_z1 | o_pa_x2 | o_pa_y2 | o_pa_z2, '0);
        i_rst = 1'b0;
        @(negedge clk);

        // k = 0 keeps the identity untouched.
        do_run("k0", '0, 1'b0, cyc_tmp, res);
        check_eq("k0_x", res.x, '0);
        check_eq("k0_y", res.y, 255'd1);
        check_eq("k0_z", res.z, 255'd1);

        // k = 1 yields the base point.
        do_run("k1", 255'd1, 1'b0, cyc_tmp, res);
        check_point("k1", res, base);

        // k = 2 and k = 2^254 + 1 against multiples from the reference model.
        ref2 = padd(base, base);
        refbig = base;
        for (int i = 0; i < 254; i++) refbig = padd(refbig, refbig);
        refbig = padd(refbig, base);
        do_run("k2", 255'd2, 1'b0, cyc2, res2);
        check_point("k2", res2, ref2);
        do_run("kbig", {1'b1, 253'd0, 1'b1}, 1'b0, cycb, res);
        check_point("kbig", res, refbig);
        check_eq("ct_cycles", 255'(cycb), 255'(cyc2));

        // Stray start and spurious results in S_DBL_REQ must not matter.
        do_run("dist", 255'd2, 1'b1, cyc_tmp, res);
        check_point("dist", res, ref2);
        check_eq("dist_same", res.x, res2.x);

        // Abort at the 100th request.
        cur_px = c_BX; cur_py = c_BY;
        @(negedge clk);
        i_start = 1'b1; i_k = 255'd1; i_px = c_BX; i_py = c_BY;
        @(negedge clk);
        i_start = 1'b0;
        reqs = 0; hit = 1'b0;
        for (int n = 0; n < 5000 && !hit; n++) begin
            if (o_pa_start) reqs++;
            if (reqs == 100) hit = 1'b1;
            else @(negedge clk);
        end
        check_eq("abort_reach", 255'(hit), 255'd1);
        b_fin = fin_cnt;
        i_rst = 1'b1;
        @(negedge clk);
        check_eq("abort_busy", 255'({o_busy, o_pa_start, o_finished}), 255'd0);
        check_eq("abort_out",  o_x | o_y | o_z, '0);
        @(negedge clk);
        i_rst = 1'b0;
        repeat (40) @(negedge clk);
        check_eq("abort_nofin", 255'(fin_cnt - b_fin), 255'd0);
        check_eq("abort_idle",  255'(o_busy), 255'd0);
        do_run("post", 255'd1, 1'b0, cyc_tmp, res);
        check_point("post", res, base);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_scalar_mult
`default_nettype wire

// File: doc/scalar_mult.md
SCALAR_MULT -- requirements
Module: scalar_mult

Interface
REQ-001 SHALL have these ports (clock and reset first):
 i_clk  in  1  sole clock, rising edge
 i_rst  in  1  synchronous, active-high reset
 i_start  in  1  one-cycle request; sampled only in S_IDLE
 i_k  in  255  scalar, sampled with i_start
 i_px, i_py  in  255 each  affine base point P (Z=1), sampled with i_start
 o_x, o_y, o_z  out  255 each  projective result k*P, held until next accepted start
 o_busy  out  1  high in every state except S_IDLE
 o_finished  out  1  one-cycle done pulse
 o_pa_start  out  1  point-operation request pulse
 o_pa_doubling  out  1  1 = doubling, 0 = addition
 o_pa_x1, o_pa_y1, o_pa_z1, o_pa_x2, o_pa_y2, o_pa_z2  out  255 each  operands
 i_pa_x3, i_pa_y3, i_pa_z3  in  255 each  point-operation result
 i_pa_finished  in  1  one-cycle result-valid pulse from the point unit
REQ-002 Clock i_clk only; reset i_rst is synchronous and active-high.
REQ-003 All outputs SHALL be driven from registers.

Function
REQ-004 Algorithm: left-to-right, constant-time double-and-always-add over bits 254..0; accumulator R starts at the identity (0,1,1).
REQ-005 FSM states: S_IDLE, S_DBL_REQ, S_DBL_WAIT, S_ADD_REQ, S_ADD_WAIT, S_DONE.
REQ-006 S_IDLE with i_start=1: latch i_k, P=(i_px,i_py,1), R=(0,1,1), bit index=254; next state S_DBL_REQ.
REQ-007 S_DBL_REQ: o_pa_start=1, o_pa_doubling=1, both operands = R; next state S_DBL_WAIT.
REQ-008 S_DBL_WAIT: on i_pa_finished, R <= (i_pa_x3,i_pa_y3,i_pa_z3); next state S_ADD_REQ.
REQ-009 S_ADD_REQ: o_pa_start=1, o_pa_doubling=0, operand 1 = R, operand 2 = P; next state S_ADD_WAIT.
REQ-010 S_ADD_WAIT: on i_pa_finished, R <= result only if k[index]=1; the result is discarded when k[index]=0. If index=0, next state is S_DONE; otherwise index decrements and the next state is S_DBL_REQ.
REQ-011 S_DONE: o_finished=1 for one cycle, o_x/o_y/o_z <= R; next state S_IDLE.
REQ-012 o_pa_start SHALL be high for exactly one cycle per operation. o_pa_x*/y*/z* and o_pa_doubling SHALL remain stable from the request cycle until the matching i_pa_finished. Operand outputs are 0 in S_IDLE.
REQ-013 Timing: the first o_pa_start occurs one cycle after i_start. Each subsequent o_pa_start occurs one cycle after i_pa_finished. o_finished occurs one cycle after the 510th i_pa_finished.
REQ-014 Exactly 510 requests per run: 255 doublings and 255 additions, strictly alternating and starting with a doubling, independent of k.
REQ-015 i_start outside S_IDLE is ignored. i_pa_finished outside the *_WAIT states is ignored.
REQ-016 All coordinates are reduced mod p = 2^255-19. The block performs no arithmetic; it only selects and transfers values.

Reset
REQ-017 i_rst SHALL force S_IDLE. It SHALL clear to 0: o_x, o_z, o_pa_*, o_finished, o_busy, the index and the latched k/P. It SHALL set o_y=0 and R=(0,1,1).
REQ-018 Reset mid-operation SHALL abort the run with no o_finished pulse. The point unit shares i_rst, so no stale i_pa_finished can follow.

Structure
REQ-019 The state enum, the identity constant and the modulus p SHALL reside in a shared ECC package used by all point-level blocks.
REQ-020 No sub-module is required. The point-add/double unit is instantiated beside this block at the parent level and connected through the o_pa_*/i_pa_* ports.

Verification
REQ-021 k=0, P=base point, model point unit with fixed 20-cycle latency -> 510 o_pa_start pulses, result (0,1,1), o_finished exactly 1 cycle after the last i_pa_finished.
REQ-022 k=1, P=Ed25519 base point -> o_x/o_z and o_y/o_z equal the base point affine coordinates.
REQ-023 k=2, then k=2^254+1 -> results equal 2P and (2^254+1)P from the reference model; total cycle count is identical for both runs.
REQ-024 i_start pulsed during a run and spurious i_pa_finished in S_DBL_REQ -> both ignored; the result is unchanged.
REQ-025 i_rst asserted at the 100th request -> S_IDLE next cycle, o_busy=0, no o_finished; a following k=1 run completes correctly.
